// File: rtl/fusion_pkg.sv
// Shared opcode constants, issue-type encodings and scheduler states for the fusion issue scheduler.
package fusion_pkg;

  localparam logic [3:0] OP_LOAD   = 4'h7;
  localparam logic [3:0] OP_STORE  = 4'h6;
  localparam logic [3:0] OP_CUSTOM = 4'hF;

  typedef enum logic [1:0] {
    TYPE_SINGLE  = 2'd0,
    TYPE_LOAD    = 2'd1,
    TYPE_STORE   = 2'd2,
    TYPE_COMPUTE = 2'd3
  } fuse_type_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_READY = 2'd2
  } sched_state_t;

  function automatic logic [3:0] opcode(input logic [15:0] inst);
    return inst[15:12];
  endfunction

endpackage

// File: rtl/fusion_pair_match.sv
// Combinational detector for the fusable head pair (A = head, B = head+1) and fused-word former.
module fusion_pair_match
  import fusion_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        match,
  output fuse_type_t  fuse_type,
  output logic [15:0] word
);

  logic is_load;
  logic is_store;
  logic is_compute;

  always_comb begin
    is_load    = (opcode(a) == OP_LOAD)   && (opcode(b) == OP_CUSTOM) && (a[11:9] == b[8:6]);
    is_store   = (opcode(a) == OP_CUSTOM) && (opcode(b) == OP_STORE)  && (a[11:9] == b[11:9]);
    is_compute = (opcode(a) == OP_CUSTOM) && (opcode(b) == OP_CUSTOM) && (a[11:10] == b[11:10]);

    match     = 1'b0;
    fuse_type = TYPE_SINGLE;
    word      = a;
    // Load wins over store, store over compute, when several patterns overlap.
    if (is_load) begin
      match     = 1'b1;
      fuse_type = TYPE_LOAD;
      word      = {b[15:6], a[5:0]};
    end else if (is_store) begin
      match     = 1'b1;
      fuse_type = TYPE_STORE;
      word      = {a[15:6], b[5:0]};
    end else if (is_compute) begin
      match     = 1'b1;
      fuse_type = TYPE_COMPUTE;
      word      = {a[15:10], a[9:6] | b[9:6], a[5:0]};
    end
  end

endmodule

// File: rtl/fusion_issue_scheduler.sv
// Instruction window that issues head instructions singly or fused with their successor,
// holding a lone head for a bounded number of cycles waiting for a partner.
module fusion_issue_scheduler
  import fusion_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_inst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        fuse_en,
  input  logic        flush,
  output logic [15:0] out_inst,
  output logic [1:0]  out_type,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] issue_count,
  output logic [31:0] fuse_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 2);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;

  sched_state_t state;
  sched_state_t next_state;

  logic        push;
  logic        slot_free;
  logic        issue;
  logic [1:0]  pops;
  logic [15:0] issue_word;
  fuse_type_t  issue_type;

  logic [15:0] head_inst;
  logic [15:0] next_inst;
  logic        pair_match;
  fuse_type_t  pair_type;
  logic [15:0] pair_word;

  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;
  assign head_inst = mem[head];
  assign next_inst = mem[head + PW'(1)];

  fusion_pair_match u_match (
    .a         (head_inst),
    .b         (next_inst),
    .match     (pair_match),
    .fuse_type (pair_type),
    .word      (pair_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= next_state;
      count    <= count_next;
      hold_cnt <= hold_next;
      head     <= head + PW'(pops);
      if (push) tail <= tail + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_inst;
  end

  // State mirrors the registered occupancy, so B is only looked at once it has really been written.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    pops       = 2'd0;
    issue_word = head_inst;
    issue_type = TYPE_SINGLE;
    hold_next  = hold_cnt;

    case (state)
      ST_HOLD: begin
        if (slot_free) begin
          if (flush || !fuse_en || (hold_cnt >= HW'(HOLD_CYCLES))) begin
            issue = 1'b1;
            pops  = 2'd1;
          end else begin
            hold_next = hold_cnt + HW'(1);
          end
        end
      end
      ST_READY: begin
        if (slot_free) begin
          issue = 1'b1;
          if (fuse_en && pair_match) begin
            pops       = 2'd2;
            issue_word = pair_word;
            issue_type = pair_type;
          end else begin
            pops = 2'd1;
          end
        end
      end
      default: ;
    endcase

    if (issue || (state != ST_HOLD)) hold_next = '0;

    count_next = count + CW'(push) - CW'(pops);

    if (count_next == '0) begin
      next_state = ST_EMPTY;
    end else if (count_next == CW'(1)) begin
      next_state = ST_HOLD;
    end else begin
      next_state = ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_inst  <= '0;
      out_type  <= '0;
      out_valid <= 1'b0;
    end else if (issue) begin
      out_inst  <= issue_word;
      out_type  <= issue_type;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_count <= '0;
      fuse_count  <= '0;
    end else if (out_valid && out_ready) begin
      issue_count <= issue_count + 32'd1;
      if (out_type != TYPE_SINGLE) fuse_count <= fuse_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fusion_issue_scheduler.sv
// Directed bench for fusion_issue_scheduler: fusion patterns, hold/flush timing,
// backpressure ordering and reset in the middle of traffic.
module tb_fusion_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_inst;
  logic        in_valid;
  logic        in_ready;
  logic        fuse_en;
  logic        flush;
  logic [15:0] out_inst;
  logic [1:0]  out_type;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] issue_count;
  logic [31:0] fuse_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fusion_issue_scheduler #(.DEPTH(4), .HOLD_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_inst     (in_inst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fuse_en     (fuse_en),
    .flush       (flush),
    .out_inst    (out_inst),
    .out_type    (out_type),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .issue_count (issue_count),
    .fuse_count  (fuse_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; flush = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_inst(input logic [15:0] v);
    in_valid = 1'b1;
    in_inst  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    fuse_en = 1'b1; out_ready = 1'b1;
    do_reset();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_inst !== 16'h0) begin fails++; $display("[TB] FAIL reset_inst: got %h expected 0000", out_inst); end
    checks++; if (out_type !== 2'd0) begin fails++; $display("[TB] FAIL reset_type: got %0d expected 0", out_type); end
    checks++; if (issue_count !== 32'd0) begin fails++; $display("[TB] FAIL reset_issue_count: got %0d expected 0", issue_count); end
    checks++; if (fuse_count !== 32'd0) begin fails++; $display("[TB] FAIL reset_fuse_count: got %0d expected 0", fuse_count); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_load_fuse();
    do_reset();
    fuse_en = 1'b1; out_ready = 1'b1;
    push_inst(16'h7215);
    push_inst(16'hF040);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL load_early_issue: got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL load_valid: got %b expected 1", out_valid); end
    checks++; if (out_inst !== 16'hF055) begin fails++; $display("[TB] FAIL load_word: got %h expected f055", out_inst); end
    checks++; if (out_type !== 2'd1) begin fails++; $display("[TB] FAIL load_type: got %0d expected 1", out_type); end
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL load_valid_drop: got %b expected 0", out_valid); end
    step();
    step();
    checks++; if (issue_count !== 32'd1) begin fails++; $display("[TB] FAIL load_issue_count: got %0d expected 1", issue_count); end
    checks++; if (fuse_count !== 32'd1) begin fails++; $display("[TB] FAIL load_fuse_count: got %0d expected 1", fuse_count); end
  endtask

  task automatic test_store_compute();
    do_reset();
    fuse_en = 1'b1; out_ready = 1'b1;
    push_inst(16'hF400);
    push_inst(16'h6423);
    step();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL store_valid: got %b expected 1", out_valid); end
    checks++; if (out_inst !== 16'hF423) begin fails++; $display("[TB] FAIL store_word: got %h expected f423", out_inst); end
    checks++; if (out_type !== 2'd2) begin fails++; $display("[TB] FAIL store_type: got %0d expected 2", out_type); end
    push_inst(16'hF840);
    push_inst(16'hF880);
    step();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL compute_valid: got %b expected 1", out_valid); end
    checks++; if (out_inst !== 16'hF8C0) begin fails++; $display("[TB] FAIL compute_word: got %h expected f8c0", out_inst); end
    checks++; if (out_type !== 2'd3) begin fails++; $display("[TB] FAIL compute_type: got %0d expected 3", out_type); end
    step();
    checks++; if (issue_count !== 32'd2) begin fails++; $display("[TB] FAIL sc_issue_count: got %0d expected 2", issue_count); end
    checks++; if (fuse_count !== 32'd2) begin fails++; $display("[TB] FAIL sc_fuse_count: got %0d expected 2", fuse_count); end
  endtask

  task automatic test_no_fuse();
    do_reset();
    fuse_en = 1'b0; out_ready = 1'b1;
    push_inst(16'h7215);
    push_inst(16'hF040);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL nofuse_first_valid: got %b expected 1", out_valid); end
    checks++; if (out_inst !== 16'h7215) begin fails++; $display("[TB] FAIL nofuse_first_word: got %h expected 7215", out_inst); end
    checks++; if (out_type !== 2'd0) begin fails++; $display("[TB] FAIL nofuse_first_type: got %0d expected 0", out_type); end
    step();
    checks++; if (out_inst !== 16'hF040) begin fails++; $display("[TB] FAIL nofuse_second_word: got %h expected f040", out_inst); end
    checks++; if (out_type !== 2'd0) begin fails++; $display("[TB] FAIL nofuse_second_type: got %0d expected 0", out_type); end
    step();
    checks++; if (issue_count !== 32'd2) begin fails++; $display("[TB] FAIL nofuse_issue_count: got %0d expected 2", issue_count); end
    checks++; if (fuse_count !== 32'd0) begin fails++; $display("[TB] FAIL nofuse_fuse_count: got %0d expected 0", fuse_count); end
    fuse_en = 1'b1;
  endtask

  task automatic test_unmatched_pair();
    int n;
    do_reset();
    fuse_en = 1'b1; out_ready = 1'b1;
    push_inst(16'h1234);
    push_inst(16'h2345);
    step();
    checks++; if (out_inst !== 16'h1234 || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL pair_first: got %h/%b expected 1234/1", out_inst, out_valid); end
    step();
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL pair_second_timeout: got valid %b expected 1 within 10 cycles", out_valid); end
    checks++; if (out_inst !== 16'h2345) begin fails++; $display("[TB] FAIL pair_second_word: got %h expected 2345", out_inst); end
    step();
    checks++; if (issue_count !== 32'd2) begin fails++; $display("[TB] FAIL pair_issue_count: got %0d expected 2", issue_count); end
    checks++; if (fuse_count !== 32'd0) begin fails++; $display("[TB] FAIL pair_fuse_count: got %0d expected 0", fuse_count); end
  endtask

  task automatic test_hold_flush();
    logic exp_valid;
    do_reset();
    fuse_en = 1'b1; out_ready = 1'b1;
    push_inst(16'h1234);
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_valid = (i == 3);
      checks++; if (out_valid !== exp_valid) begin fails++; $display("[TB] FAIL hold_timing_cycle%0d: got %b expected %b", i, out_valid, exp_valid); end
    end
    checks++; if (out_inst !== 16'h1234 || out_type !== 2'd0) begin fails++; $display("[TB] FAIL hold_word: got %h/%0d expected 1234/0", out_inst, out_type); end
    step();
    checks++; if (issue_count !== 32'd1) begin fails++; $display("[TB] FAIL hold_issue_count: got %0d expected 1", issue_count); end

    do_reset();
    push_inst(16'h1234);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL flush_valid: got %b expected 1", out_valid); end
    checks++; if (out_inst !== 16'h1234) begin fails++; $display("[TB] FAIL flush_word: got %h expected 1234", out_inst); end
  endtask

  task automatic test_backpressure();
    logic [15:0] seq [5];
    int idx;
    seq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    do_reset();
    fuse_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_in_ready_%0d: got %b expected 1", i, in_ready); end
      push_inst(seq[i]);
    end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_full: got in_ready %b expected 0", in_ready); end
    in_valid = 1'b1; in_inst = 16'h6666;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_inst !== 16'h1111 || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_stable_%0d: got %h/%b expected 1111/1", i, out_inst, out_valid); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_blocked_%0d: got in_ready %b expected 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
      if (out_valid) begin
        checks++; if (out_inst !== seq[idx]) begin fails++; $display("[TB] FAIL bp_order_%0d: got %h expected %h", idx, out_inst, seq[idx]); end
        idx++;
      end
      step();
    end
    checks++; if (idx != 5) begin fails++; $display("[TB] FAIL bp_drain: got %0d issues expected 5", idx); end
    checks++; if (issue_count !== 32'd5) begin fails++; $display("[TB] FAIL bp_issue_count: got %0d expected 5", issue_count); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_idle: got valid %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    fuse_en = 1'b1; out_ready = 1'b0;
    push_inst(16'h1111);
    push_inst(16'h2222);
    push_inst(16'h3333);
    push_inst(16'h4444);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL mid_pre_valid: got %b expected 1", out_valid); end
    rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_valid: got %b expected 0", out_valid); end
    checks++; if (out_inst !== 16'h0 || out_type !== 2'd0) begin fails++; $display("[TB] FAIL mid_out: got %h/%0d expected 0000/0", out_inst, out_type); end
    checks++; if (issue_count !== 32'd0 || fuse_count !== 32'd0) begin fails++; $display("[TB] FAIL mid_counts: got %0d/%0d expected 0/0", issue_count, fuse_count); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
    out_ready = 1'b1;
    push_inst(16'h7215);
    push_inst(16'hF040);
    step();
    checks++; if (out_inst !== 16'hF055 || out_type !== 2'd1 || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL mid_after: got %h/%0d/%b expected f055/1/1", out_inst, out_type, out_valid); end
    step();
    checks++; if (issue_count !== 32'd1 || fuse_count !== 32'd1) begin fails++; $display("[TB] FAIL mid_after_counts: got %0d/%0d expected 1/1", issue_count, fuse_count); end
  endtask

  initial begin
    rst = 1'b1; in_inst = '0; in_valid = 1'b0; fuse_en = 1'b1; flush = 1'b0; out_ready = 1'b1;
    test_reset();
    test_load_fuse();
    test_store_compute();
    test_no_fuse();
    test_unmatched_pair();
    test_hold_flush();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
